spi_slave_sync: RTL and testbench
=================================

Name: spi_slave_sync

Overview:
- Next-generation SPI slave core, fully synchronous to the system clock; the current core is clocked directly by sclk.
- Oversamples ssel/sclk/mosi through synchronisers and selects the SPI mode (CPOL/CPHA) at run time, per transfer.
- Bit order and word width are parametrised.
- Provides valid/ready handshakes on both the tx and rx data paths, plus underrun/overrun detection, for direct attachment to system-clock logic or FIFOs.

Parameters:
- DATA_WDT, 8, word width in bits (≥4).
- SYNC_STAGES, 2, synchroniser flops on ssel/sclk/mosi (≥2).
- LSB_FIRST, 0, 1 = shift LSB first on both miso and mosi.
- IDLE_WORD, '0, word transmitted when txValid is low at a word load.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous reset, active high.
- cpol  input  1  clock polarity; sampled when ssel asserts.
- cpha  input  1  clock phase; sampled when ssel asserts.
- ssel  input  1  active-low slave select (asynchronous).
- sclk  input  1  SPI clock (asynchronous).
- mosi  input  1  master out, slave in (asynchronous).
- miso  output  1  slave out data, registered.
- misoEn  output  1  miso output enable for the pad tristate.
- txData  input  DATA_WDT  word to transmit.
- txValid  input  1  txData is valid.
- txReady  output  1  one-clk pulse: txData accepted this cycle.
- rxData  output  DATA_WDT  received word.
- rxValid  output  1  rxData is valid; held until rxReady.
- rxReady  input  1  consumer accepts rxData.
- busy  output  1  transfer in progress (synchronised ssel low).
- txUnderrun  output  1  sticky: a word load occurred with txValid low.
- rxOverrun  output  1  sticky: a word completed while rxValid was still high.

Behaviour:
- Reset values: miso=0, misoEn=0, txReady=0, rxValid=0, rxData=0, busy=0, txUnderrun=0, rxOverrun=0; state IDLE.
- Synchronisation: ssel, sclk and mosi each pass through SYNC_STAGES flops. Edges are detected against an extra delay flop.
- Timing requirement: sclk high and low times must each be ≥ SYNC_STAGES+2 clk periods.
- Edge definitions: sclkNorm = sclk_s ^ cpolLat. Leading edge = sclkNorm rising. Trailing edge = sclkNorm falling.
  - cphaLat=0: sample on leading edge, shift on trailing edge.
  - cphaLat=1: shift on leading edge, sample on trailing edge.
- FSM IDLE -> ACTIVE on synchronised ssel falling edge:
  - latch cpol/cpha into cpolLat/cphaLat;
  - clear bitCnt;
  - set misoEn=1 and busy=1.
- If cphaLat=0, the first word is loaded in that same entry cycle.
- FSM ACTIVE -> IDLE on synchronised ssel rising edge, from any bit position:
  - misoEn=0, busy=0, bitCnt cleared;
  - a partial rx word is discarded, with no rxValid and no overrun;
  - miso holds its last value.
- Word load (tx):
  - Load events: the cphaLat=0 entry cycle; a cphaLat=0 shift edge that follows sample number DATA_WDT; a cphaLat=1 shift edge with bitCnt=0.
  - If txValid=1: shift register <= txData and txReady pulses high for exactly that clk.
  - Otherwise: shift register <= IDLE_WORD and txUnderrun <= 1.
  - miso presents the first bit (MSB, or LSB if LSB_FIRST) in the clk after the load.
- Shifting (tx): each later shift edge within a word advances miso by one bit.
- Sampling (rx): each sample edge shifts mosi_s into the rx register and increments bitCnt (0..DATA_WDT-1, wraps to 0).
- Word complete: on sample number DATA_WDT:
  - rxData <= assembled word, with bit order per LSB_FIRST;
  - rxValid <= 1;
  - if rxValid was already 1 and rxReady=0 in that cycle, rxOverrun <= 1 and rxData is overwritten with the new word.
- Rx handshake: rxValid clears in the clk after rxValid&rxReady. A word completing in the same cycle as the handshake sets rxValid without an overrun.
- Back-to-back words: continuous sclk across word boundaries is supported with no gap cycles.
- Sticky flags: txUnderrun and rxOverrun clear only on reset, or on ssel falling edge (new transfer).
- Glitch handling: a mode change on cpol/cpha during ACTIVE is ignored. An sclk edge while IDLE is ignored.

Optional Feature:
- Macro: SPI_SLAVE_STATUS_EN.
- Defined: txUnderrun and rxOverrun are implemented as described above.
- Undefined: both outputs are tied to 0, the detection logic is removed, and rxData is still overwritten on overrun.

Test Plan:
- Mode 0, DATA_WDT=8, txData=0xA5 valid, master sends 0x3C -> miso carries 1,0,1,0,0,1,0,1 on consecutive leading edges; rxData=0x3C with rxValid=1; exactly one txReady pulse.
- Modes 1, 2 and 3, each with tx 0x5A and master byte 0xC3 -> rxData=0xC3 and master receives 0x5A in every mode; cpol/cpha changed mid-transfer have no effect.
- Two back-to-back bytes with continuous sclk; tx 0x11 then 0x22; rxReady held 0 -> second byte overwrites rxData=second value and rxOverrun=1. Repeat with rxReady=1 -> rxOverrun stays 0.
- txValid=0 at load, IDLE_WORD=0xFF -> master receives 0xFF, txUnderrun=1, no txReady pulse; next ssel falling edge clears txUnderrun.
- ssel deasserted after 5 bits -> busy=0, misoEn=0, no rxValid; next full transfer of 0x81 received correctly from bit 0.
- LSB_FIRST=1, tx 0x01 -> first miso bit is 1; master sends 0x80 LSB-first -> rxData=0x80. Also assert reset mid-byte -> all outputs return to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/spi_slave_sync.sv
// SPI slave running entirely on clk: ssel/sclk/mosi are oversampled, CPOL/CPHA are latched per transfer.
// Define SPI_SLAVE_STATUS_EN to build the sticky txUnderrun/rxOverrun flags; otherwise they read 0.
module spi_slave_sync #(
   parameter int                  DATA_WDT    = 8,
   parameter int                  SYNC_STAGES = 2,
   parameter int                  LSB_FIRST   = 0,
   parameter logic [DATA_WDT-1:0] IDLE_WORD   = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cpol,
   input  logic                cpha,
   input  logic                ssel,
   input  logic                sclk,
   input  logic                mosi,
   output logic                miso,
   output logic                misoEn,
   input  logic [DATA_WDT-1:0] txData,
   input  logic                txValid,
   output logic                txReady,
   output logic [DATA_WDT-1:0] rxData,
   output logic                rxValid,
   input  logic                rxReady,
   output logic                busy,
   output logic                txUnderrun,
   output logic                rxOverrun
);
   localparam int               CNT_W    = $clog2(DATA_WDT);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WDT - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} stateType;
   stateType state;

   logic [SYNC_STAGES-1:0] sselSync, sclkSync, mosiSync;
   logic                   sselDly, sclkDly;
   logic                   cpolLat, cphaLat;
   logic [CNT_W-1:0]       bitCnt;
   logic [DATA_WDT-1:0]    txShift, rxShift;

   logic                   sselS, sclkS, mosiS, sselFall, sselRise;
   logic                   sclkNorm, sclkNormDly, leadEdge, trailEdge;
   logic                   entry, inXfer, shiftEdge, sampleEdge, loadEvt, wordDone;
   logic [DATA_WDT-1:0]    loadWord, rxNext;

   // Input synchronisers plus one delay flop for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sselSync <= {SYNC_STAGES{1'b1}};
         sclkSync <= {SYNC_STAGES{1'b0}};
         mosiSync <= {SYNC_STAGES{1'b0}};
         sselDly  <= 1'b1;
         sclkDly  <= 1'b0;
      end else begin
         sselSync <= {sselSync[SYNC_STAGES-2:0], ssel};
         sclkSync <= {sclkSync[SYNC_STAGES-2:0], sclk};
         mosiSync <= {mosiSync[SYNC_STAGES-2:0], mosi};
         sselDly  <= sselSync[SYNC_STAGES-1];
         sclkDly  <= sclkSync[SYNC_STAGES-1];
      end
   end

   // Edge classification and per-cycle transfer events
   always_comb begin
      sselS       = sselSync[SYNC_STAGES-1];
      sclkS       = sclkSync[SYNC_STAGES-1];
      mosiS       = mosiSync[SYNC_STAGES-1];
      sselFall    = sselDly & ~sselS;
      sselRise    = ~sselDly & sselS;
      sclkNorm    = sclkS ^ cpolLat;
      sclkNormDly = sclkDly ^ cpolLat;
      leadEdge    = sclkNorm & ~sclkNormDly;
      trailEdge   = ~sclkNorm & sclkNormDly;
      entry       = (state == IDLE) & sselFall;
      inXfer      = (state == ACTIVE) & ~sselRise;
      shiftEdge   = inXfer & (cphaLat ? leadEdge : trailEdge);
      sampleEdge  = inXfer & (cphaLat ? trailEdge : leadEdge);
      // bitCnt is zero on a shift edge only at a word boundary, for either phase
      loadEvt     = (entry & ~cpha) | (shiftEdge & (bitCnt == CNT_ZERO));
      wordDone    = sampleEdge & (bitCnt == LAST_BIT);
      loadWord    = txValid ? txData : IDLE_WORD;
      rxNext      = (LSB_FIRST != 0) ? {mosiS, rxShift[DATA_WDT-1:1]}
                                     : {rxShift[DATA_WDT-2:0], mosiS};
   end

   // Transfer FSM with tx/rx datapaths and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cpolLat <= 1'b0;
         cphaLat <= 1'b0;
         bitCnt  <= CNT_ZERO;
         txShift <= {DATA_WDT{1'b0}};
         rxShift <= {DATA_WDT{1'b0}};
         rxData  <= {DATA_WDT{1'b0}};
         rxValid <= 1'b0;
         txReady <= 1'b0;
         miso    <= 1'b0;
         misoEn  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         txReady <= 1'b0;
         if (rxValid && rxReady) begin
            rxValid <= 1'b0;
         end
         if (loadEvt) begin
            txReady <= txValid;
            if (LSB_FIRST != 0) begin
               miso    <= loadWord[0];
               txShift <= {1'b0, loadWord[DATA_WDT-1:1]};
            end else begin
               miso    <= loadWord[DATA_WDT-1];
               txShift <= {loadWord[DATA_WDT-2:0], 1'b0};
            end
         end else if (shiftEdge) begin
            if (LSB_FIRST != 0) begin
               miso    <= txShift[0];
               txShift <= {1'b0, txShift[DATA_WDT-1:1]};
            end else begin
               miso    <= txShift[DATA_WDT-1];
               txShift <= {txShift[DATA_WDT-2:0], 1'b0};
            end
         end
         if (sampleEdge) begin
            rxShift <= rxNext;
            bitCnt  <= wordDone ? CNT_ZERO : bitCnt + CNT_ONE;
         end
         if (wordDone) begin
            rxData  <= rxNext;
            rxValid <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (sselFall) begin
                  state   <= ACTIVE;
                  cpolLat <= cpol;
                  cphaLat <= cpha;
                  bitCnt  <= CNT_ZERO;
                  misoEn  <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            ACTIVE: begin
               // A partial word is simply dropped; miso keeps its last value
               if (sselRise) begin
                  state  <= IDLE;
                  bitCnt <= CNT_ZERO;
                  misoEn <= 1'b0;
                  busy   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef SPI_SLAVE_STATUS_EN
   // Sticky status flags, cleared when a new transfer starts
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         txUnderrun <= 1'b0;
         rxOverrun  <= 1'b0;
      end else begin
         if (entry) begin
            txUnderrun <= 1'b0;
            rxOverrun  <= 1'b0;
         end
         if (loadEvt && !txValid) begin
            txUnderrun <= 1'b1;
         end
         if (wordDone && rxValid && !rxReady) begin
            rxOverrun <= 1'b1;
         end
      end
   end
`else
   assign txUnderrun = 1'b0;
   assign rxOverrun  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: dutA is MSB-first with IDLE_WORD 0xFF, dutB is LSB-first.
module tb_spi_slave_sync;
   localparam int H = 8;
`ifdef SPI_SLAVE_STATUS_EN
   localparam logic STATUS_ON = 1'b1;
`else
   localparam logic STATUS_ON = 1'b0;
`endif

   logic clk = 1'b0, reset = 1'b1;
   logic cpol = 1'b0, cpha = 1'b0, ssel = 1'b1, sclk = 1'b0, mosi = 1'b0;
   logic miso, misoEn, txReady, rxValid, busy, txUnderrun, rxOverrun;
   logic [7:0] txData = 8'h00, rxData;
   logic txValid = 1'b0, rxReady = 1'b0;
   logic misoB, misoEnB, txReadyB, rxValidB, busyB, txUnderrunB, rxOverrunB;
   logic [7:0] rxDataB;
   logic [7:0] txDataB = 8'h01;
   logic txValidB = 1'b1, rxReadyB = 1'b0;

   int checks = 0, failures = 0;
   int txPulses = 0, txPulsesB = 0;
   logic [7:0] txQ[$];
   logic [7:0] rxGot[$];

   always #5 clk = ~clk;

   spi_slave_sync #(.DATA_WDT(8), .SYNC_STAGES(2), .LSB_FIRST(0), .IDLE_WORD(8'hFF)) dutA (
      .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .ssel(ssel), .sclk(sclk), .mosi(mosi),
      .miso(miso), .misoEn(misoEn), .txData(txData), .txValid(txValid), .txReady(txReady),
      .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady), .busy(busy),
      .txUnderrun(txUnderrun), .rxOverrun(rxOverrun));

   spi_slave_sync #(.DATA_WDT(8), .SYNC_STAGES(3), .LSB_FIRST(1), .IDLE_WORD(8'h00)) dutB (
      .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .ssel(ssel), .sclk(sclk), .mosi(mosi),
      .miso(misoB), .misoEn(misoEnB), .txData(txDataB), .txValid(txValidB), .txReady(txReadyB),
      .rxData(rxDataB), .rxValid(rxValidB), .rxReady(rxReadyB), .busy(busyB),
      .txUnderrun(txUnderrunB), .rxOverrun(rxOverrunB));

   // One clk step on the falling edge; also acts as tx producer and rx consumer
   task automatic tick();
      @(negedge clk);
      if (txReady) begin
         txPulses++;
         if (txQ.size() > 0) void'(txQ.pop_front());
      end
      if (txReadyB) txPulsesB++;
      if (rxValid && rxReady) rxGot.push_back(rxData);
      txValid = (txQ.size() > 0);
      txData  = (txQ.size() > 0) ? txQ[0] : 8'h00;
   endtask

   task automatic waitHalf();
      for (int i = 0; i < H; i++) tick();
   endtask

   task automatic drainRx();
      rxReady = 1'b1;
      tick();
      tick();
      rxReady = 1'b0;
   endtask

   function automatic int bitPos(int k, logic lsbM);
      int j;
      j = k % 8;
      return ((k / 8) == 0 ? 8 : 0) + (lsbM ? j : 7 - j);
   endfunction

   // SPI master: nBits bits from wordsIn (first word in [15:8]); returns what it read from miso
   task automatic spiXfer(input logic cpolM, input logic cphaM, input logic glitch, input logic lsbM,
                          input logic selB, input int nBits, input logic [15:0] wordsIn,
                          output logic [15:0] rcv, output logic firstBit);
      rcv = 16'h0000;
      firstBit = 1'b0;
      cpol = cpolM;
      cpha = cphaM;
      sclk = cpolM;
      mosi = wordsIn[bitPos(0, lsbM)];
      waitHalf();
      ssel = 1'b0;
      waitHalf();
      for (int k = 0; k < nBits; k++) begin
         sclk = ~cpolM;
         if (!cphaM) rcv[bitPos(k, lsbM)] = selB ? misoB : miso;
         else mosi = wordsIn[bitPos(k, lsbM)];
         if (k == 0) firstBit = selB ? misoB : miso;
         waitHalf();
         sclk = cpolM;
         if (cphaM) begin
            rcv[bitPos(k, lsbM)] = selB ? misoB : miso;
            if (k == 0) firstBit = selB ? misoB : miso;
         end else if (k + 1 < nBits) begin
            mosi = wordsIn[bitPos(k + 1, lsbM)];
         end
         if (glitch && k == 3) begin
            cpol = ~cpolM;
            cpha = ~cphaM;
         end
         waitHalf();
      end
      ssel = 1'b1;
      waitHalf();
      waitHalf();
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks += 8;
      if (miso !== 1'b0)       begin failures++; $display("FAIL reset_miso: got %b expected 0", miso); end
      if (misoEn !== 1'b0)     begin failures++; $display("FAIL reset_misoEn: got %b expected 0", misoEn); end
      if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (txReady !== 1'b0)    begin failures++; $display("FAIL reset_txReady: got %b expected 0", txReady); end
      if (rxValid !== 1'b0)    begin failures++; $display("FAIL reset_rxValid: got %b expected 0", rxValid); end
      if (rxData !== 8'h00)    begin failures++; $display("FAIL reset_rxData: got %h expected 00", rxData); end
      if (txUnderrun !== 1'b0) begin failures++; $display("FAIL reset_txUnderrun: got %b expected 0", txUnderrun); end
      if (rxOverrun !== 1'b0)  begin failures++; $display("FAIL reset_rxOverrun: got %b expected 0", rxOverrun); end
      reset = 1'b0;
      waitHalf();
   endtask

   task automatic test_mode0();
      logic [15:0] r;
      logic fb;
      txQ.push_back(8'hA5);
      txPulses = 0;
      spiXfer(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 16'h3C00, r, fb);
      checks += 6;
      if (r[15:8] !== 8'hA5)  begin failures++; $display("FAIL m0_miso_bits: got %h expected a5", r[15:8]); end
      if (rxData !== 8'h3C)   begin failures++; $display("FAIL m0_rxData: got %h expected 3c", rxData); end
      if (rxValid !== 1'b1)   begin failures++; $display("FAIL m0_rxValid: got %b expected 1", rxValid); end
      if (txPulses !== 1)     begin failures++; $display("FAIL m0_txReady_pulses: got %0d expected 1", txPulses); end
      if (busy !== 1'b0)      begin failures++; $display("FAIL m0_busy_end: got %b expected 0", busy); end
      if (misoEn !== 1'b0)    begin failures++; $display("FAIL m0_misoEn_end: got %b expected 0", misoEn); end
      drainRx();
   endtask

   task automatic test_modes();
      logic [15:0] r;
      logic fb;
      logic [1:0] m;
      for (int mi = 1; mi < 4; mi++) begin
         m = 2'(mi);
         txQ.push_back(8'h5A);
         spiXfer(m[1], m[0], 1'b1, 1'b0, 1'b0, 8, 16'hC300, r, fb);
         checks += 3;
         if (r[15:8] !== 8'h5A) begin failures++; $display("FAIL mode%0d_master_rx: got %h expected 5a", mi, r[15:8]); end
         if (rxData !== 8'hC3)  begin failures++; $display("FAIL mode%0d_rxData: got %h expected c3", mi, rxData); end
         if (rxValid !== 1'b1)  begin failures++; $display("FAIL mode%0d_rxValid: got %b expected 1", mi, rxValid); end
         drainRx();
         txQ.delete();
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] r;
      logic fb;
      txQ.push_back(8'h11);
      txQ.push_back(8'h22);
      txPulses = 0;
      spiXfer(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16, 16'h9669, r, fb);
      checks += 4;
      if (r !== 16'h1122)          begin failures++; $display("FAIL b2b_master_rx: got %h expected 1122", r); end
      if (rxData !== 8'h69)        begin failures++; $display("FAIL b2b_rxData_overwrite: got %h expected 69", rxData); end
      if (rxOverrun !== STATUS_ON) begin failures++; $display("FAIL b2b_rxOverrun: got %b expected %b", rxOverrun, STATUS_ON); end
      if (txPulses !== 2)          begin failures++; $display("FAIL b2b_txReady_pulses: got %0d expected 2", txPulses); end
      drainRx();
      rxGot.delete();
      txQ.push_back(8'h33);
      txQ.push_back(8'h44);
      rxReady = 1'b1;
      spiXfer(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16, 16'hA50F, r, fb);
      rxReady = 1'b0;
      checks += 5;
      if (r !== 16'h3344)     begin failures++; $display("FAIL b2b_ready_master_rx: got %h expected 3344", r); end
      if (rxGot.size() !== 2) begin failures++; $display("FAIL b2b_ready_words: got %0d expected 2", rxGot.size()); end
      else if (rxGot[0] !== 8'hA5 || rxGot[1] !== 8'h0F)
         begin failures++; $display("FAIL b2b_ready_values: got %h %h expected a5 0f", rxGot[0], rxGot[1]); end
      if (rxOverrun !== 1'b0) begin failures++; $display("FAIL b2b_ready_rxOverrun: got %b expected 0", rxOverrun); end
      if (rxValid !== 1'b0)   begin failures++; $display("FAIL b2b_ready_rxValid: got %b expected 0", rxValid); end
      txQ.delete();
   endtask

   task automatic test_underrun();
      logic [15:0] r;
      logic fb;
      txQ.delete();
      txPulses = 0;
      spiXfer(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8, 16'h5500, r, fb);
      checks += 3;
      if (r[15:8] !== 8'hFF)        begin failures++; $display("FAIL ur_master_rx: got %h expected ff", r[15:8]); end
      if (txUnderrun !== STATUS_ON) begin failures++; $display("FAIL ur_txUnderrun: got %b expected %b", txUnderrun, STATUS_ON); end
      if (txPulses !== 0)           begin failures++; $display("FAIL ur_txReady_pulses: got %0d expected 0", txPulses); end
      drainRx();
   endtask

   task automatic test_abort();
      logic [15:0] r;
      logic fb;
      txQ.push_back(8'h3C);
      spiXfer(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5, 16'hFF00, r, fb);
      checks += 4;
      if (busy !== 1'b0)       begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
      if (misoEn !== 1'b0)     begin failures++; $display("FAIL abort_misoEn: got %b expected 0", misoEn); end
      if (rxValid !== 1'b0)    begin failures++; $display("FAIL abort_rxValid: got %b expected 0", rxValid); end
      if (txUnderrun !== 1'b0) begin failures++; $display("FAIL abort_txUnderrun_cleared: got %b expected 0", txUnderrun); end
      txQ.delete();
      txQ.push_back(8'h7E);
      spiXfer(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8, 16'h8100, r, fb);
      checks += 3;
      if (rxData !== 8'h81)  begin failures++; $display("FAIL abort_next_rxData: got %h expected 81", rxData); end
      if (rxValid !== 1'b1)  begin failures++; $display("FAIL abort_next_rxValid: got %b expected 1", rxValid); end
      if (r[15:8] !== 8'h7E) begin failures++; $display("FAIL abort_next_master_rx: got %h expected 7e", r[15:8]); end
      drainRx();
   endtask

   task automatic test_lsb_first();
      logic [15:0] r;
      logic fb;
      txPulsesB = 0;
      spiXfer(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8, 16'h8000, r, fb);
      checks += 7;
      if (fb !== 1'b1)              begin failures++; $display("FAIL lsb_first_bit: got %b expected 1", fb); end
      if (r[15:8] !== 8'h01)        begin failures++; $display("FAIL lsb_master_rx: got %h expected 01", r[15:8]); end
      if (rxDataB !== 8'h80)        begin failures++; $display("FAIL lsb_rxData: got %h expected 80", rxDataB); end
      if (rxValidB !== 1'b1)        begin failures++; $display("FAIL lsb_rxValid: got %b expected 1", rxValidB); end
      if (txPulsesB !== 2)          begin failures++; $display("FAIL lsb_txReady_pulses: got %0d expected 2", txPulsesB); end
      if (busyB !== 1'b0 || misoEnB !== 1'b0 || txUnderrunB !== 1'b0)
         begin failures++; $display("FAIL lsb_idle_flags: got busy=%b misoEn=%b txUnderrun=%b expected 0 0 0", busyB, misoEnB, txUnderrunB); end
      if (rxOverrunB !== STATUS_ON) begin failures++; $display("FAIL lsb_rxOverrun: got %b expected %b", rxOverrunB, STATUS_ON); end
   endtask

   task automatic test_async_reset();
      txQ.push_back(8'hA5);
      cpol = 1'b0;
      cpha = 1'b0;
      sclk = 1'b0;
      mosi = 1'b1;
      waitHalf();
      ssel = 1'b0;
      waitHalf();
      for (int i = 0; i < 2; i++) begin
         sclk = 1'b1;
         waitHalf();
         sclk = 1'b0;
         waitHalf();
      end
      checks += 3;
      if (busy !== 1'b1)    begin failures++; $display("FAIL pre_reset_busy: got %b expected 1", busy); end
      if (miso !== 1'b1)    begin failures++; $display("FAIL pre_reset_miso: got %b expected 1", miso); end
      if (rxData !== 8'h01) begin failures++; $display("FAIL pre_reset_rxData: got %h expected 01", rxData); end
      #2 reset = 1'b1;
      #1;
      checks += 6;
      if (busy !== 1'b0)    begin failures++; $display("FAIL areset_busy: got %b expected 0", busy); end
      if (misoEn !== 1'b0)  begin failures++; $display("FAIL areset_misoEn: got %b expected 0", misoEn); end
      if (miso !== 1'b0)    begin failures++; $display("FAIL areset_miso: got %b expected 0", miso); end
      if (rxValid !== 1'b0) begin failures++; $display("FAIL areset_rxValid: got %b expected 0", rxValid); end
      if (rxData !== 8'h00) begin failures++; $display("FAIL areset_rxData: got %h expected 00", rxData); end
      if (txUnderrun !== 1'b0 || rxOverrun !== 1'b0)
         begin failures++; $display("FAIL areset_flags: got %b %b expected 0 0", txUnderrun, rxOverrun); end
      ssel = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_modes();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_lsb_first();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
